// File: rtl/drac_pkg.sv
// -----------------------------------------------------------------------------
// drac_pkg
// Shared front-end types: fetch/decode stage bundle, decoded instruction entry,
// exception and branch-prediction encodings, decode buffer depth and the
// I-type immediate helper used by the decoder.
// -----------------------------------------------------------------------------
package drac_pkg;

   localparam int XLEN          = 32;
   localparam int DEC_BUF_DEPTH = 4;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   typedef enum logic [3:0] {
      INSTR_ADDR_MISALIGNED = 4'd0,
      INSTR_ACCESS_FAULT    = 4'd1,
      ILLEGAL_INSTR         = 4'd2,
      BREAKPOINT            = 4'd3,
      NONE                  = 4'hF
   } exception_cause_t;

   typedef struct packed {
      exception_cause_t  cause;
      logic [XLEN-1:0]   origin;
      logic              valid;
   } exception_t;

   typedef enum logic {
      PRED_NOT_TAKEN = 1'b0,
      PRED_TAKEN     = 1'b1
   } branch_pred_decision_t;

   typedef struct packed {
      branch_pred_decision_t decision;
      logic [XLEN-1:0]       pred_addr;
   } branch_pred_t;

   typedef struct packed {
      logic [XLEN-1:0] pc_inst;
      logic [31:0]     inst;
      logic            valid;
      exception_t      ex;
      branch_pred_t    bpred;
   } if_id_stage_t;

   typedef enum logic [3:0] {
      INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
      INSTR_SLLI, INSTR_SRLI, INSTR_SRAI, INSTR_LUI, INSTR_ADD, INSTR_SUB,
      INSTR_ILLEGAL
   } instr_type_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      branch_pred_t    bpred;
      exception_t      ex;
      instr_type_t     instr_type;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            use_imm;
      logic            regfile_we;
   } instr_entry_t;

   // Sign-extended 12-bit I-type immediate.
   function automatic logic [XLEN-1:0] imm_i(input logic [31:0] inst);
      return {{(XLEN-12){inst[31]}}, inst[31:20]};
   endfunction

endpackage

// File: rtl/decode_buffer_decoder.sv
// -----------------------------------------------------------------------------
// decode_buffer_decoder
// Combinational RV32 subset decoder (OP-IMM, OP add/sub, LUI).
// Ports:
//   decode_i        in   if_id_stage_t   fetched instruction bundle
//   decode_instr_o  out  instr_entry_t   decoded entry; ex and bpred copied as-is
// Unsupported encodings decode to INSTR_ILLEGAL with no register write; the
// incoming exception field is never modified here.
// -----------------------------------------------------------------------------
module decode_buffer_decoder
   import drac_pkg::*;
(
   input  if_id_stage_t decode_i,
   output instr_entry_t decode_instr_o
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;

   assign w_opcode = decode_i.inst[6:0];
   assign w_funct3 = decode_i.inst[14:12];
   assign w_funct7 = decode_i.inst[31:25];

   // NOTE: every field gets a default before the case so no path leaves a
   // field unassigned, which would otherwise infer a latch.
   always_comb begin
      decode_instr_o            = '0;
      decode_instr_o.valid      = decode_i.valid;
      decode_instr_o.pc         = decode_i.pc_inst;
      decode_instr_o.bpred      = decode_i.bpred;
      decode_instr_o.ex         = decode_i.ex;
      decode_instr_o.rs1        = decode_i.inst[19:15];
      decode_instr_o.rs2        = decode_i.inst[24:20];
      decode_instr_o.rd         = decode_i.inst[11:7];
      decode_instr_o.instr_type = INSTR_ILLEGAL;

      case (w_opcode)
         OP_IMM: begin
            decode_instr_o.use_imm = 1'b1;
            decode_instr_o.imm     = imm_i(decode_i.inst);
            case (w_funct3)
               3'b000: decode_instr_o.instr_type = INSTR_ADDI;
               3'b010: decode_instr_o.instr_type = INSTR_SLTI;
               3'b011: decode_instr_o.instr_type = INSTR_SLTIU;
               3'b100: decode_instr_o.instr_type = INSTR_XORI;
               3'b110: decode_instr_o.instr_type = INSTR_ORI;
               3'b111: decode_instr_o.instr_type = INSTR_ANDI;
               3'b001: begin
                  decode_instr_o.imm = {{(XLEN-5){1'b0}}, decode_i.inst[24:20]};
                  if (w_funct7 == 7'b0000000) decode_instr_o.instr_type = INSTR_SLLI;
               end
               default: begin // 3'b101: logical or arithmetic right shift
                  decode_instr_o.imm = {{(XLEN-5){1'b0}}, decode_i.inst[24:20]};
                  if (w_funct7 == 7'b0000000)      decode_instr_o.instr_type = INSTR_SRLI;
                  else if (w_funct7 == 7'b0100000) decode_instr_o.instr_type = INSTR_SRAI;
               end
            endcase
         end
         OP_LUI: begin
            decode_instr_o.use_imm    = 1'b1;
            decode_instr_o.imm        = {decode_i.inst[31:12], 12'b0};
            decode_instr_o.instr_type = INSTR_LUI;
         end
         OP_REG: begin
            if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000)      decode_instr_o.instr_type = INSTR_ADD;
            else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) decode_instr_o.instr_type = INSTR_SUB;
         end
         default: ;
      endcase

      decode_instr_o.regfile_we = (decode_instr_o.instr_type != INSTR_ILLEGAL);
   end

endmodule

// File: rtl/decode_buffer.sv
// -----------------------------------------------------------------------------
// decode_buffer
// Decode-stage front buffer: decodes one fetched instruction per cycle and
// queues the decoded entry in a DEPTH-entry FIFO, decoupling fetch from
// downstream backpressure. Optionally halts input after an excepting entry.
// Ports:
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous reset, active-high
//   flush_i         in   drop all entries and the current input, return to RUN
//   decode_i        in   fetched instruction bundle
//   decode_ready_o  out  buffer accepts decode_i this cycle (registered state only)
//   decode_instr_o  out  head entry
//   decode_valid_o  out  head entry valid
//   deq_ready_i     in   consumer takes the head when valid
//   count_o         out  occupied entries
//   halted_o        out  input refused until flush after an exception
// -----------------------------------------------------------------------------
module decode_buffer
   import drac_pkg::*;
#(
   parameter int DEPTH       = DEC_BUF_DEPTH,
   parameter bit HALT_ON_EXC = 1'b1
)(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  if_id_stage_t               decode_i,
   output logic                       decode_ready_o,
   output instr_entry_t               decode_instr_o,
   output logic                       decode_valid_o,
   input  logic                       deq_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       halted_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic {RUN, HALT_EXC} state_t;

   instr_entry_t     r_storage [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   state_t           r_state;
   state_t           w_state_next;
   instr_entry_t     w_decoded;
   logic             w_enq;
   logic             w_deq;

   decode_buffer_decoder u_decoder (
      .decode_i       (decode_i),
      .decode_instr_o (w_decoded)
   );

   assign decode_ready_o = (r_count != CNT_W'(DEPTH)) && (r_state == RUN);
   assign decode_valid_o = (r_count != '0);
   assign decode_instr_o = r_storage[r_rd_ptr];
   assign count_o        = r_count;
   assign halted_o       = (r_state == HALT_EXC);

   assign w_enq = decode_i.valid & decode_ready_o & ~flush_i;
   assign w_deq = decode_valid_o & deq_ready_i & ~flush_i;

   // NOTE: the storage array is deliberately not reset; occupancy is tracked by
   // r_count, so stale contents are never reported as valid.
   always_ff @(posedge clk_i) begin
      if (w_enq) r_storage[r_wr_ptr] <= w_decoded;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its peers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= RUN;
      end else begin
         r_state <= w_state_next;
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_enq, w_deq})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN:      if (w_enq && decode_i.ex.valid && HALT_ON_EXC) w_state_next = HALT_EXC;
         HALT_EXC: w_state_next = HALT_EXC;
         default:  w_state_next = RUN;
      endcase
      if (flush_i) w_state_next = RUN;
   end

   a_no_enq_full:  assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(w_enq && r_count == CNT_W'(DEPTH)));
   a_no_deq_empty: assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(w_deq && r_count == '0));
   a_count_bound:  assert property (@(posedge clk_i) disable iff (rst_i)
                                    r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;
   import drac_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   if_id_stage_t din;
   logic         deq_ready;

   logic         ready, valid, halted;
   instr_entry_t head;
   logic [2:0]   count;

   logic         nh_ready, nh_valid, nh_halted;
   instr_entry_t nh_head;
   logic [2:0]   nh_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      bit          exv;
   } exp_t;

   exp_t q[$];
   bit   m_halt;

   always #5 clk = ~clk;

   decode_buffer #(.DEPTH(4), .HALT_ON_EXC(1'b1)) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .decode_i(din),
      .decode_ready_o(ready), .decode_instr_o(head), .decode_valid_o(valid),
      .deq_ready_i(deq_ready), .count_o(count), .halted_o(halted)
   );

   decode_buffer #(.DEPTH(4), .HALT_ON_EXC(1'b0)) u_dut_nh (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .decode_i(din),
      .decode_ready_o(nh_ready), .decode_instr_o(nh_head), .decode_valid_o(nh_valid),
      .deq_ready_i(deq_ready), .count_o(nh_count), .halted_o(nh_halted)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic if_id_stage_t mk(input bit v, input logic [31:0] pc,
                                       input logic [31:0] inst, input bit exv);
      if_id_stage_t s;
      s                 = '0;
      s.valid           = v;
      s.pc_inst         = pc;
      s.inst            = inst;
      s.ex.valid        = exv;
      s.ex.cause        = exv ? ILLEGAL_INSTR : NONE;
      s.ex.origin       = exv ? inst : 32'h0;
      s.bpred.decision  = PRED_NOT_TAKEN;
      s.bpred.pred_addr = 32'h0;
      return s;
   endfunction

   // One clock with a small reference queue: checks ready/valid/head before the
   // edge and the occupancy after it.
   task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                        input bit exv, input bit dr, input bit fl);
      bit   m_ready, m_valid;
      exp_t e;
      din       = mk(v, pc, inst, exv);
      deq_ready = dr;
      flush     = fl;
      m_ready   = (q.size() != 4) && !m_halt;
      m_valid   = (q.size() != 0);
      check("ready", ready, m_ready);
      check("valid", valid, m_valid);
      if (m_valid) begin
         check("head_pc", head.pc, q[0].pc);
         check("head_exv", head.ex.valid, q[0].exv);
      end
      if (fl) begin
         q.delete();
         m_halt = 1'b0;
      end else begin
         if (m_valid && dr) void'(q.pop_front());
         if (v && m_ready) begin
            e.pc  = pc;
            e.exv = exv;
            q.push_back(e);
            if (exv) m_halt = 1'b1;
         end
      end
      tick();
      din   = mk(0, 32'h0, 32'h0, 0);
      flush = 1'b0;
      check("count", count, 64'(q.size()));
      check("halted", halted, m_halt);
   endtask

   logic [31:0] vec_inst [4] = '{32'hfff02013, 32'h00003013, 32'h00500013, 32'h00804013};
   instr_type_t vec_type [4] = '{INSTR_SLTI, INSTR_SLTIU, INSTR_ADDI, INSTR_XORI};
   logic [31:0] vec_imm  [4] = '{32'hFFFFFFFF, 32'h0, 32'h5, 32'h8};

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      deq_ready = 1'b0;
      din       = mk(0, 32'h0, 32'h0, 0);
      m_halt    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_valid", valid, 0);
      check("rst_count", count, 0);
      check("rst_halted", halted, 0);
      rst = 1'b0;
      tick();

      // Single instruction: addi x0,x0,5 at 0x2008, consumer always ready.
      cycle(1, 32'h2008, 32'h00500013, 0, 1, 0);
      check("single_type", head.instr_type, INSTR_ADDI);
      check("single_imm", head.imm, 32'h5);
      check("single_rd", head.rd, 0);
      check("single_pc", head.pc, 32'h2008);
      cycle(0, 32'h0, 32'h0, 0, 1, 0);

      // Fill to full, try one more, then drain in order with decode checks.
      for (int i = 0; i < 4; i++) cycle(1, 32'h2000 + 32'(4*i), vec_inst[i], 0, 0, 0);
      cycle(1, 32'h3000, 32'h00100013, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         check("drain_type", head.instr_type, vec_type[i]);
         check("drain_imm", head.imm, vec_imm[i]);
         cycle(0, 32'h0, 32'h0, 0, 1, 0);
      end

      // Invalid input with garbage contents is ignored.
      cycle(0, 32'hDEAD, 32'hdeadbeef, 0, 0, 0);

      // Refill six across the wrap point while draining.
      for (int i = 0; i < 6; i++) cycle(1, 32'h2100 + 32'(4*i), 32'h00500013, 0, (i >= 3), 0);
      while (q.size() != 0) cycle(0, 32'h0, 32'h0, 0, 1, 0);

      // Simultaneous enqueue/dequeue at count 2.
      cycle(1, 32'h2200, 32'h00003013, 0, 0, 0);
      cycle(1, 32'h2204, 32'h00003013, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(1, 32'h2208 + 32'(4*i), 32'h00804013, 0, 1, 0);
      check("simul_count", count, 2);
      while (q.size() != 0) cycle(0, 32'h0, 32'h0, 0, 1, 0);

      // Exception entry halts input; it drains with ex intact; flush resumes.
      cycle(1, 32'h2300, 32'hffffffff, 1, 0, 0);
      check("exc_ready", ready, 0);
      check("exc_cause", head.ex.cause, ILLEGAL_INSTR);
      check("exc_type", head.instr_type, INSTR_ILLEGAL);
      check("nh_ready", nh_ready, 1);
      check("nh_halted", nh_halted, 0);
      cycle(1, 32'h2304, 32'h00500013, 0, 1, 0);
      check("exc_drained", count, 0);
      cycle(0, 32'h0, 32'h0, 0, 0, 1);
      check("flush_ready", ready, 1);
      check("flush_nh_count", nh_count, 0);

      // Flush with a concurrent enqueue at count 3.
      for (int i = 0; i < 3; i++) cycle(1, 32'h2400 + 32'(4*i), 32'h00500013, 0, 0, 0);
      cycle(1, 32'h4444, 32'h00500013, 0, 0, 1);
      check("flush_valid", valid, 0);
      cycle(1, 32'h5000, 32'h00500013, 0, 0, 0);
      check("post_flush_pc", head.pc, 32'h5000);
      cycle(0, 32'h0, 32'h0, 0, 1, 0);

      // Asynchronous reset mid-stream with count 3 while halted.
      cycle(1, 32'h2500, 32'h00500013, 0, 0, 0);
      cycle(1, 32'h2504, 32'h00500013, 0, 0, 0);
      cycle(1, 32'h2508, 32'hffffffff, 1, 0, 0);
      check("pre_rst_count", count, 3);
      rst = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_valid", valid, 0);
      check("arst_ready", ready, 1);
      check("arst_halted", halted, 0);
      q.delete();
      m_halt = 1'b0;
      tick();
      rst = 1'b0;
      cycle(0, 32'h0, 32'h0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
